// File: rtl/arb_pkg.sv
// Shared types for the four-way round-robin bus arbiter.
// No logic, so no latency.
// No flow control; types only.
//
// Contents: NUM_REQ, req_idx_t, arb_state_t, idx_to_onehot().
package arb_pkg;

    localparam int NUM_REQ = 4;

    typedef logic [1:0] req_idx_t;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    function automatic logic [NUM_REQ-1:0] idx_to_onehot(input req_idx_t idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_1.sv
// Four-input steering mux for the shared bus data.
// Purely combinational, zero cycles.
// No flow control.
//
// Ports: sel input index, din four WIDTH-bit inputs, dout selected input.
module mux4_1 #(
    parameter int WIDTH = 64
) (
    input  logic [1:0]            sel,
    input  logic [3:0][WIDTH-1:0] din,
    output logic [WIDTH-1:0]      dout
);

    assign dout = din[sel];

endmodule

// File: rtl/rr_pick4.sv
// Rotate-priority picker: first asserted request at ptr, ptr+1, ... (mod 4).
// Purely combinational, zero cycles.
// No flow control; the caller decides when the winner is consumed.
//
// Ports: req[3:0] request vector, ptr starting index,
//        winner chosen index (equals ptr when nothing requests), any_req.
module rr_pick4
    import arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  req_idx_t           ptr,
    output req_idx_t           winner,
    output logic               any_req
);

    always_comb begin
        req_idx_t cand;
        winner  = ptr;
        any_req = |req;
        cand    = ptr;
        // Walk from the farthest offset back to offset 0 so the closest
        // requester to ptr is the last assignment and therefore wins.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + req_idx_t'(k);
            if (req[cand]) begin
                winner = cand;
            end
        end
    end

endmodule

// File: rtl/rr_bus_arbiter4.sv
// Round-robin owner of one shared WIDTH-bit bus among four burst requesters.
// Grant one cycle after req in IDLE; zero-bubble handoff on final beat; data path is combinational.
// Beats stall while bus_ready is low; owner keeps the bus (revoked after MAX_HOLD stalls with ARB_TIMEOUT_EN).
//
// Optional feature macro: ARB_TIMEOUT_EN (stall-timeout grant revocation).
// Ports: clk, reset_n (async active-low), req/last/req_data per requester,
//        bus_ready from downstream; grant (one-hot), sel, bus_valid,
//        bus_data, bus_last toward downstream; timeout revoke pulse.
module rr_bus_arbiter4
    import arb_pkg::*;
#(
    parameter int WIDTH    = 64,
    parameter int MAX_HOLD = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [3:0]            req,
    input  logic [3:0]            last,
    input  logic [3:0][WIDTH-1:0] req_data,
    input  logic                  bus_ready,
    output logic [3:0]            grant,
    output logic [1:0]            sel,
    output logic                  bus_valid,
    output logic [WIDTH-1:0]      bus_data,
    output logic                  bus_last,
    output logic                  timeout
);

    arb_state_t state;
    req_idx_t   ptr;
    req_idx_t   pick_ptr;
    req_idx_t   winner;
    logic       any_req;
    logic       owner_req;
    logic       xfer;
    logic       revoke;
    logic       release_bus;

    assign owner_req   = req[sel];
    assign bus_valid   = (state == OWN) & owner_req;
    assign bus_last    = bus_valid & last[sel];
    assign xfer        = bus_valid & bus_ready;
    assign release_bus = (state == OWN) & ((xfer & last[sel]) | ~owner_req | revoke);

    // In OWN the only arbitration that matters is the handoff one, which
    // starts just past the current owner; in IDLE it starts at ptr.
    assign pick_ptr = (state == OWN) ? (sel + 2'd1) : ptr;

    rr_pick4 u_pick (
        .req     (req),
        .ptr     (pick_ptr),
        .winner  (winner),
        .any_req (any_req)
    );

    mux4_1 #(
        .WIDTH (WIDTH)
    ) u_mux (
        .sel  (sel),
        .din  (req_data),
        .dout (bus_data)
    );

`ifdef ARB_TIMEOUT_EN
    localparam int HOLD_W = $clog2(MAX_HOLD + 1);

    logic [HOLD_W-1:0] hold_cnt;
    logic              load_grant;

    assign load_grant = any_req & ((state == IDLE) | release_bus);
    assign revoke     = (state == OWN) & ~xfer & (hold_cnt == HOLD_W'(MAX_HOLD));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt <= '0;
            timeout  <= 1'b0;
        end else begin
            timeout <= revoke;
            if (load_grant || xfer) begin
                hold_cnt <= '0;
            end else if (state == OWN) begin
                hold_cnt <= hold_cnt + 1'b1;
            end
        end
    end
`else
    // Without the timeout feature a stalled owner keeps the bus forever.
    localparam int unused_max_hold = MAX_HOLD;

    assign revoke  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            ptr   <= '0;
            grant <= '0;
            sel   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state <= OWN;
                        grant <= idx_to_onehot(winner);
                        sel   <= winner;
                    end
                end
                OWN: begin
                    if (release_bus) begin
                        ptr <= sel + 2'd1;
                        if (any_req) begin
                            grant <= idx_to_onehot(winner);
                            sel   <= winner;
                        end else begin
                            state <= IDLE;
                            grant <= '0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rr_bus_arbiter4.sv
// Bench for the four-way round-robin bus arbiter.
// Inputs change 1 time unit after the falling clock edge; outputs compared on the falling edge.
// Reference model tracks owner/pointer as integers and picks winners by a plain scan.
module tb_rr_bus_arbiter4;

    localparam int WIDTH    = 64;
    localparam int MAX_HOLD = 4;
`ifdef ARB_TIMEOUT_EN
    localparam int TO_EN = 1;
`else
    localparam int TO_EN = 0;
`endif

    logic                  clk;
    logic                  reset_n;
    logic [3:0]            req;
    logic [3:0]            last;
    logic [3:0][WIDTH-1:0] req_data;
    logic                  bus_ready;
    logic [3:0]            grant;
    logic [1:0]            sel;
    logic                  bus_valid;
    logic [WIDTH-1:0]      bus_data;
    logic                  bus_last;
    logic                  timeout;

    int total = 0;
    int bad   = 0;

    rr_bus_arbiter4 #(
        .WIDTH    (WIDTH),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .last      (last),
        .req_data  (req_data),
        .bus_ready (bus_ready),
        .grant     (grant),
        .sel       (sel),
        .bus_valid (bus_valid),
        .bus_data  (bus_data),
        .bus_last  (bus_last),
        .timeout   (timeout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int   own_m;   // owner index, -1 when nobody holds the bus
    int   ptr_m;
    int   sel_m;
    int   hold_m;
    logic to_m;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < 4; k++) begin
            if (r[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        int   w;
        logic xf;
        logic rv;
        if (!reset_n) begin
            own_m  = -1;
            ptr_m  = 0;
            sel_m  = 0;
            hold_m = 0;
            to_m   = 1'b0;
        end else begin
            to_m = 1'b0;
            if (own_m < 0) begin
                w = pick(req, ptr_m);
                if (w >= 0) begin
                    own_m  = w;
                    sel_m  = w;
                    hold_m = 0;
                end
            end else begin
                xf = req[own_m] && bus_ready;
                rv = (TO_EN != 0) && !xf && (hold_m == MAX_HOLD);
                if ((xf && last[own_m]) || !req[own_m] || rv) begin
                    ptr_m  = (own_m + 1) % 4;
                    to_m   = rv;
                    w      = pick(req, ptr_m);
                    own_m  = w;
                    if (w >= 0) sel_m = w;
                    hold_m = 0;
                end else begin
                    hold_m = xf ? 0 : hold_m + 1;
                end
            end
        end
    end

    // Every falling edge: DUT outputs against the model.
    always @(negedge clk) begin
        logic [3:0] g_e;
        logic       v_e;
        g_e = (own_m < 0) ? 4'b0000 : (4'b0001 << own_m);
        v_e = (own_m >= 0) && req[own_m];
        check("m_grant", 64'(grant), 64'(g_e));
        check("m_sel", 64'(sel), 64'(sel_m));
        check("m_bus_valid", 64'(bus_valid), 64'(v_e));
        check("m_bus_last", 64'(bus_last), 64'(v_e && last[own_m]));
        check("m_timeout", 64'(timeout), 64'(to_m));
        if (v_e) check("m_bus_data", bus_data, req_data[own_m]);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic [3:0] rot [5];
        int         odd_cycles;
        rot[0] = 4'b0001; rot[1] = 4'b0010; rot[2] = 4'b0100; rot[3] = 4'b1000; rot[4] = 4'b0001;

        reset_n   = 1'b0;
        req       = 4'b1111;
        last      = 4'b1111;
        bus_ready = 1'b1;
        for (int i = 0; i < 4; i++) req_data[i] = 64'h1000 + 64'(i);

        // Reset held with every request up.
        repeat (2) @(negedge clk);
        check("rst_grant", 64'(grant), 64'h0);
        check("rst_valid", 64'(bus_valid), 64'h0);
        check("rst_sel", 64'(sel), 64'h0);
        #1 reset_n = 1'b1;

        // Single-beat bursts from all four: strict rotation, no bubbles.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("rot%0d_grant", i), 64'(grant), 64'(rot[i]));
        end
        check("rot_sel0", 64'(sel), 64'h0);
        #1 req = 4'b0000;
        @(negedge clk);
        check("idle_after_rot", 64'(grant), 64'h0);

        // Requester 0 alone, three beats, stall on beat 2.
        #1 req = 4'b0001; last = 4'b0000; bus_ready = 1'b1; req_data[0] = 64'hA1;
        @(negedge clk);
        check("b1_grant", 64'(grant), 64'h1);
        check("b1_data", bus_data, 64'hA1);
        #1 req_data[0] = 64'hA2; bus_ready = 1'b0;
        @(negedge clk);
        check("b2_valid", 64'(bus_valid), 64'h1);
        check("b2_data", bus_data, 64'hA2);
        @(negedge clk);
        check("b2_hold_grant", 64'(grant), 64'h1);
        #1 bus_ready = 1'b1;
        @(negedge clk);
        #1 req_data[0] = 64'hA3; last = 4'b0001;
        #1 check("b3_last", 64'(bus_last), 64'h1);
        check("b3_data", bus_data, 64'hA3);
        @(negedge clk);
        check("b3_rewin_sole", 64'(grant), 64'h1);
        #1 req = 4'b0000; last = 4'b0000;
        @(negedge clk);
        check("b3_idle", 64'(grant), 64'h0);

        // Owner 2 aborts mid-burst while requester 3 waits.
        #1 req = 4'b0100;
        @(negedge clk);
        check("ab_grant2", 64'(grant), 64'h4);
        check("ab_sel2", 64'(sel), 64'h2);
        #1 req = 4'b1100;
        @(negedge clk);
        #1 req = 4'b1000;
        #1 check("ab_no_last", 64'(bus_last), 64'h0);
        check("ab_no_valid", 64'(bus_valid), 64'h0);
        @(negedge clk);
        check("ab_grant3", 64'(grant), 64'h8);
        check("ab_sel3", 64'(sel), 64'h3);
        #1 req = 4'b1001; last = 4'b1000;
        @(negedge clk);
        check("ab_wrap_to0", 64'(grant), 64'h1);
        #1 req = 4'b0000; last = 4'b0000;
        @(negedge clk);

        // Stalled owner.
        #1 req = 4'b0011; bus_ready = 1'b0;
        @(negedge clk);
        check("st_grant1", 64'(grant), 64'h2);
`ifdef ARB_TIMEOUT_EN
        repeat (4) @(negedge clk);
        check("st_pre_to_grant", 64'(grant), 64'h2);
        check("st_pre_to", 64'(timeout), 64'h0);
        @(negedge clk);
        check("st_to_pulse", 64'(timeout), 64'h1);
        check("st_to_grant0", 64'(grant), 64'h1);
        @(negedge clk);
        check("st_to_once", 64'(timeout), 64'h0);
`else
        odd_cycles = 0;
        repeat (100) begin
            @(negedge clk);
            if (grant !== 4'b0010 || timeout !== 1'b0) odd_cycles++;
        end
        check("st_hold100", 64'(odd_cycles), 64'h0);
        check("st_hold_grant", 64'(grant), 64'h2);
`endif

        // Reset in the middle of a burst.
        #1 last = 4'b0011;
        #1 reset_n = 1'b0;
        #1 check("mr_grant", 64'(grant), 64'h0);
        check("mr_valid", 64'(bus_valid), 64'h0);
        check("mr_last", 64'(bus_last), 64'h0);
        @(negedge clk);
        #1 reset_n = 1'b1;
        @(negedge clk);
        check("mr_restart_grant", 64'(grant), 64'h1);
        check("mr_restart_sel", 64'(sel), 64'h0);

        #1 req = 4'b0000;
        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
